btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving consecutive stable synchronized samples needed to accept a level change; legal range 1..65535.
REQ-002 SHALL have parameter BTN_ACTIVE_LOW, default 0; when 1, raw button inputs are inverted at the input before synchronization.
REQ-003 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port btn_raw, input, 3, unsynchronized push-button levels; bit i is button i.
REQ-006 SHALL have port btn_level, output, 3, debounced level per button, 1 = pressed.
REQ-007 SHALL have port press_pulse, output, 3, one-cycle strobe per button on each accepted press.
REQ-008 SHALL have port press_valid, output, 1, a press event is pending for the consumer.
REQ-009 SHALL have port press_code, output, 2, pending event code: 00/01/10 = button 0/1/2, 11 = simultaneous multi-press.
REQ-010 SHALL have port press_ack, input, 1, consumer accepts the pending event.
REQ-011 SHALL have port overrun, output, 1, sticky flag: a press was dropped while an event was pending.
REQ-012 SHALL have port overrun_clr, input, 1, synchronous clear of overrun.

Function
REQ-013 SHALL pass each btn_raw bit through a two-flop synchronizer before any other use.
REQ-014 SHALL run per button a 4-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-015 SHALL transition RELEASED->PRESS_WAIT when the synchronized level is 1; PRESS_WAIT counts consecutive 1 samples, returns to RELEASED on any 0 sample, and enters PRESSED on the DEBOUNCE_CYCLES-th consecutive 1.
REQ-016 SHALL mirror that behaviour for release: PRESSED->RELEASE_WAIT on a 0 sample, back to PRESSED on a 1 sample, and RELEASED on the DEBOUNCE_CYCLES-th consecutive 0.
REQ-017 SHALL size each debounce counter as $clog2(DEBOUNCE_CYCLES+1) bits, clear it on every state entry, and never let it wrap.
REQ-018 SHALL assert btn_level[i] while button i is in PRESSED or RELEASE_WAIT.
REQ-019 SHALL assert press_pulse[i] for exactly one cycle, the first cycle btn_level[i] is 1; a release produces no pulse.
REQ-020 SHALL capture an event in the cycle after any press_pulse bit is set, provided no event is pending or press_ack is high in the capture-decision cycle.
REQ-021 SHALL encode the captured event as the button index when exactly one press_pulse bit was set, and as 11 when two or more were set in the same cycle.
REQ-022 SHALL hold press_valid and press_code stable until the cycle after press_ack is sampled high while press_valid is 1.
REQ-023 SHALL ignore press_ack when press_valid is 0.
REQ-024 SHALL replace an acked event with a new capture in the same edge when the ack and the new press coincide, so press_valid stays 1 with the new code.
REQ-025 SHALL give press_valid a latency of DEBOUNCE_CYCLES+3 rising edges from the first edge at which btn_raw is stably asserted.

Reset
REQ-026 SHALL, while reset is 0, force synchronizers to released, all FSMs to RELEASED, counters to 0, and btn_level, press_pulse, press_valid, press_code and overrun to 0.
REQ-027 SHALL, when reset is asserted mid-press, require a full release-free DEBOUNCE_CYCLES qualification after reset release before the next pulse; a button held across reset produces one press.

Configuration
REQ-028 SHALL, with BTN_COND_OVERRUN_EN defined, set overrun when a press is dropped because an event is pending and not acked, keeping it set until overrun_clr or reset; overrun_clr takes priority over a simultaneous drop.
REQ-029 SHALL, without BTN_COND_OVERRUN_EN, tie overrun to 0, ignore overrun_clr and synthesize no overrun logic; dropping behaviour is unchanged.

Structure
REQ-030 SHALL place the button-code constants (00, 01, 10, multi-press 11) and the FSM state typedef in the shared game package used by the game FSM.
REQ-031 SHALL implement one per-button sub-module, btn_debounce (synchronizer, FSM, counter, pulse), instantiated three times, with event capture and overrun logic in the top.

Verification
REQ-032 SHALL cover a clean press of btn_raw=001 with N=4, held 20 cycles: press_pulse=001 for one cycle, press_valid=1 and press_code=00 seven edges after the press, holding until ack.
REQ-033 SHALL cover bounce of btn_raw[1] toggling every 2 cycles for 10 cycles, then stable: no pulse during bounce, exactly one press with press_code=01 after stabilization.
REQ-034 SHALL cover btn_raw=101 applied on the same cycle: one event with press_code=11, and press_pulse=101.
REQ-035 SHALL cover a button-2 press while an unacked button-0 event is pending: press_code stays 00 and overrun=1; overrun_clr then gives overrun=0; with the macro undefined, overrun stays 0.
REQ-036 SHALL cover press_ack asserted on the same edge as a new button-1 capture: press_valid stays 1 and press_code changes to 01.
REQ-037 SHALL cover reset pulsed low while btn_raw=010 is held in PRESSED: all outputs 0 immediately, then one new press_pulse=010 DEBOUNCE_CYCLES+2 edges after reset release.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// btn_conditioner_pkg
// Shared definitions for the push-button conditioner and the game FSM that
// consumes its events: button event codes, the per-button debounce state
// type and a helper that turns a set of simultaneous press strobes into a
// single event code.
// -----------------------------------------------------------------------------
package btn_conditioner_pkg;

   localparam int NUM_BTN = 3;

   // Event codes presented on press_code
   localparam logic [1:0] CODE_BTN0  = 2'b00;
   localparam logic [1:0] CODE_BTN1  = 2'b01;
   localparam logic [1:0] CODE_BTN2  = 2'b10;
   localparam logic [1:0] CODE_MULTI = 2'b11;

   // Per-button debounce FSM states
   typedef enum logic [1:0] {
      ST_RELEASED     = 2'b00,
      ST_PRESS_WAIT   = 2'b01,
      ST_PRESSED      = 2'b10,
      ST_RELEASE_WAIT = 2'b11
   } btn_state_e;

   // Encode the press strobes seen in one cycle. Only meaningful when at
   // least one bit is set; two or more bits collapse to CODE_MULTI.
   function automatic logic [1:0] encode_press(input logic [NUM_BTN-1:0] p);
      logic [1:0] code;
      case (p)
         3'b001:  code = CODE_BTN0;
         3'b010:  code = CODE_BTN1;
         3'b100:  code = CODE_BTN2;
         default: code = CODE_MULTI;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// -----------------------------------------------------------------------------
// btn_conditioner_if
// Event handshake between the button conditioner (master) and its consumer
// (slave).
//   press_valid : event pending (master -> slave)
//   press_code  : pending event code (master -> slave)
//   press_ack   : consumer accepts the pending event (slave -> master)
//   overrun     : sticky "press dropped while pending" flag (master -> slave)
//   overrun_clr : synchronous clear of overrun (slave -> master)
//   dbg_state   : {btn2, btn1, btn0} debounce FSM states, 2 bits each
//
// Handshake: an event transfers on a rising edge where press_valid and
// press_ack are both 1. press_valid/press_code are stable from the edge that
// raises press_valid until the edge after that transfer; press_ack is
// ignored while press_valid is 0.
// -----------------------------------------------------------------------------
interface btn_conditioner_if;
   logic       press_valid;
   logic [1:0] press_code;
   logic       press_ack;
   logic       overrun;
   logic       overrun_clr;
   logic [5:0] dbg_state;

   modport master (
      output press_valid, press_code, overrun, dbg_state,
      input  press_ack, overrun_clr
   );

   modport slave (
      input  press_valid, press_code, overrun, dbg_state,
      output press_ack, overrun_clr
   );
endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One push-button channel: input polarity fix-up, two-flop synchronizer,
// four-state debounce FSM with a saturating-free counter, and a one-cycle
// press strobe.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   btn_raw_i : unsynchronized raw button level
//   level_o   : debounced level, 1 = pressed
//   pulse_o   : one-cycle strobe on the first cycle level_o is 1
//   state_o   : current FSM state (debug)
// -----------------------------------------------------------------------------
module btn_debounce
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_raw_i,
   output logic       level_o,
   output logic       pulse_o,
   output btn_state_e state_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // The sample that leaves a stable state is the first of the run, so the
   // wait state finishes when the counter holds DEBOUNCE_CYCLES-2.
   localparam int LAST = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
   localparam logic [CW-1:0] CNT_LAST = CW'(LAST);
   // With a single required sample the wait states are skipped entirely.
   localparam bit INSTANT = (DEBOUNCE_CYCLES == 1);

   logic       raw_in;
   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   btn_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic       pulse_q, pulse_d;

   // Polarity is fixed before synchronization so reset value 0 = released.
   assign raw_in  = btn_raw_i ^ BTN_ACTIVE_LOW;
   assign sync1_d = raw_in;
   assign sync2_d = sync1_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
         ST_RELEASED: begin
            if (sync2_q) begin
               cnt_d = '0;
               if (INSTANT) begin
                  state_d = ST_PRESSED;
                  pulse_d = 1'b1;
               end else begin
                  state_d = ST_PRESS_WAIT;
               end
            end
         end
         ST_PRESS_WAIT: begin
            if (!sync2_q) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_PRESSED: begin
            if (!sync2_q) begin
               cnt_d = '0;
               if (INSTANT) begin
                  state_d = ST_RELEASED;
               end else begin
                  state_d = ST_RELEASE_WAIT;
               end
            end
         end
         ST_RELEASE_WAIT: begin
            if (sync2_q) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= ST_RELEASED;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign level_o = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
   assign pulse_o = pulse_q;
   assign state_o = state_q;

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Three-button front end: debounces each button, strobes accepted presses and
// queues a single pending event (button index or multi-press) for a consumer.
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   btn_raw     : raw button levels, bit i = button i
//   btn_level   : debounced levels, 1 = pressed
//   press_pulse : one-cycle strobe per button on each accepted press
//   ev          : event handshake (press_valid/press_code/press_ack,
//                 overrun/overrun_clr, debug FSM states)
// Optional feature: define BTN_COND_OVERRUN_EN to build the sticky overrun
// flag; otherwise overrun is tied low and overrun_clr is ignored.
// -----------------------------------------------------------------------------
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_BTN-1:0]  btn_raw,
   output logic [NUM_BTN-1:0]  btn_level,
   output logic [NUM_BTN-1:0]  press_pulse,
   btn_conditioner_if.master   ev
);

   btn_state_e st [NUM_BTN];

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
      ) u_deb (
         .clock     (clock),
         .reset     (reset),
         .btn_raw_i (btn_raw[i]),
         .level_o   (btn_level[i]),
         .pulse_o   (press_pulse[i]),
         .state_o   (st[i])
      );
   end

   assign ev.dbg_state = {st[2], st[1], st[0]};

   // ---------------------------------------------------------------------
   // Event capture
   // ---------------------------------------------------------------------
   logic       valid_q, valid_d;
   logic [1:0] code_q, code_d;
   logic       any_press;
   logic       take;

   assign any_press = |press_pulse;
   // An ack in the same cycle frees the slot, so the new press replaces the
   // acknowledged event without a bubble.
   assign take      = any_press && (!valid_q || ev.press_ack);

   always_comb begin
      valid_d = valid_q;
      code_d  = code_q;
      if (take) begin
         valid_d = 1'b1;
         code_d  = encode_press(press_pulse);
      end else if (valid_q && ev.press_ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         valid_q <= valid_d;
         code_q  <= code_d;
      end
   end

   assign ev.press_valid = valid_q;
   assign ev.press_code  = code_q;

   // ---------------------------------------------------------------------
   // Overrun flag
   // ---------------------------------------------------------------------
`ifdef BTN_COND_OVERRUN_EN
   logic overrun_q, overrun_d;
   logic drop;

   assign drop = any_press && valid_q && !ev.press_ack;

   // Clear wins over a drop in the same cycle.
   always_comb begin
      overrun_d = overrun_q;
      if (ev.overrun_clr) begin
         overrun_d = 1'b0;
      end else if (drop) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign ev.overrun = overrun_q;
`else
   logic unused_overrun_clr;
   assign unused_overrun_clr = ev.overrun_clr;
   assign ev.overrun         = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;
   import btn_conditioner_pkg::*;

   localparam int N = 4;
`ifdef BTN_COND_OVERRUN_EN
   localparam int OVR_EXP = 1;
`else
   localparam int OVR_EXP = 0;
`endif

   // clock / reset
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] btn_raw = 3'b000;
   logic [2:0] btn_level;
   logic [2:0] press_pulse;

   btn_conditioner_if ev_if ();

   btn_conditioner #(
      .DEBOUNCE_CYCLES (N),
      .BTN_ACTIVE_LOW  (1'b0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .press_pulse (press_pulse),
      .ev          (ev_if.master)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard
   int         total = 0;
   int         bad   = 0;
   logic [1:0] exp_q [$];

   typedef struct {
      string      name;
      logic [2:0] pat;
      logic [2:0] exp_pulse;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Bench model of the event code from the set of newly pressed buttons.
   function automatic logic [1:0] model_code(input logic [2:0] p);
      if ($countones(p) > 1) return 2'b11;
      for (int i = 0; i < 3; i++) begin
         if (p[i]) return 2'(i);
      end
      return 2'b00;
   endfunction

   task automatic pop_chk(input string name);
      if (exp_q.size() == 0) begin
         chk({name, " scoreboard empty"}, 1, 0);
      end else begin
         chk({name, " code"}, int'(ev_if.press_code), int'(exp_q.pop_front()));
      end
   endtask

   // Drive a pattern from a released, idle state and check the full press
   // path: pulse timing, valid latency and event code.
   task automatic do_press(input string name, input logic [2:0] pat, input logic [2:0] exp_pulse);
      int         lat;
      int         pulse_cyc;
      logic [2:0] pulse_or;
      lat       = 0;
      pulse_cyc = 0;
      pulse_or  = 3'b000;
      btn_raw   = pat;
      exp_q.push_back(model_code(exp_pulse));
      while (!ev_if.press_valid && lat < 40) begin
         tick();
         lat++;
         pulse_or |= press_pulse;
         if (press_pulse != 3'b000) pulse_cyc++;
      end
      chk({name, " latency"}, lat, N + 3);
      chk({name, " pulse bits"}, int'(pulse_or), int'(exp_pulse));
      chk({name, " pulse cycles"}, pulse_cyc, 1);
      chk({name, " pulse gone"}, int'(press_pulse), 0);
      chk({name, " level"}, int'(btn_level), int'(pat));
      pop_chk(name);
   endtask

   task automatic ack_release(input string name);
      logic [2:0] pulse_or;
      pulse_or = 3'b000;
      ev_if.press_ack = 1'b1;
      tick();
      ev_if.press_ack = 1'b0;
      chk({name, " ack clears valid"}, int'(ev_if.press_valid), 0);
      btn_raw = 3'b000;
      repeat (N + 4) begin
         tick();
         pulse_or |= press_pulse;
      end
      chk({name, " no pulse on release"}, int'(pulse_or), 0);
      chk({name, " released level"}, int'(btn_level), 0);
   endtask

   initial begin
      vec_t       vecs [7];
      logic [2:0] pulse_or;
      int         k;
      bit         stable;

      vecs[0] = '{"single b0", 3'b001, 3'b001};
      vecs[1] = '{"single b1", 3'b010, 3'b010};
      vecs[2] = '{"single b2", 3'b100, 3'b100};
      vecs[3] = '{"multi 101", 3'b101, 3'b101};
      vecs[4] = '{"multi 011", 3'b011, 3'b011};
      vecs[5] = '{"multi 110", 3'b110, 3'b110};
      vecs[6] = '{"multi 111", 3'b111, 3'b111};

      ev_if.press_ack   = 1'b0;
      ev_if.overrun_clr = 1'b0;

      // reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst level", int'(btn_level), 0);
      chk("rst pulse", int'(press_pulse), 0);
      chk("rst valid", int'(ev_if.press_valid), 0);
      chk("rst code", int'(ev_if.press_code), 0);
      chk("rst overrun", int'(ev_if.overrun), 0);
      chk("rst fsm states", int'(ev_if.dbg_state), 0);
      reset = 1'b1;
      tick();

      // ack while idle is ignored
      ev_if.press_ack = 1'b1;
      tick();
      ev_if.press_ack = 1'b0;
      chk("idle ack ignored", int'(ev_if.press_valid), 0);

      // table-driven presses
      for (int i = 0; i < 7; i++) begin
         do_press(vecs[i].name, vecs[i].pat, vecs[i].exp_pulse);
         if (i == 0) begin
            chk("b0 fsm pressed", int'(ev_if.dbg_state[1:0]), int'(ST_PRESSED));
            stable = 1'b1;
            repeat (20) begin
               tick();
               if (!ev_if.press_valid || ev_if.press_code != 2'b00 || press_pulse != 3'b000)
                  stable = 1'b0;
            end
            chk("b0 hold until ack", int'(stable), 1);
         end
         ack_release(vecs[i].name);
      end

      // bounce on button 1
      pulse_or = 3'b000;
      for (int i = 0; i < 10; i++) begin
         btn_raw = (((i / 2) % 2) == 0) ? 3'b010 : 3'b000;
         tick();
         pulse_or |= press_pulse;
      end
      btn_raw = 3'b000;
      repeat (4) begin
         tick();
         pulse_or |= press_pulse;
      end
      chk("bounce no pulse", int'(pulse_or), 0);
      chk("bounce no event", int'(ev_if.press_valid), 0);
      do_press("bounce settle", 3'b010, 3'b010);
      ack_release("bounce settle");

      // press while an event is pending: dropped, overrun flagged
      do_press("ovr first", 3'b001, 3'b001);
      btn_raw  = 3'b101;
      pulse_or = 3'b000;
      repeat (N + 4) begin
         tick();
         pulse_or |= press_pulse;
      end
      chk("ovr b2 pulse", int'(pulse_or), 3'b100);
      chk("ovr valid kept", int'(ev_if.press_valid), 1);
      chk("ovr code kept", int'(ev_if.press_code), 0);
      chk("ovr flag", int'(ev_if.overrun), OVR_EXP);
      tick();
      chk("ovr sticky", int'(ev_if.overrun), OVR_EXP);
      ev_if.overrun_clr = 1'b1;
      tick();
      ev_if.overrun_clr = 1'b0;
      chk("ovr cleared", int'(ev_if.overrun), 0);
      ack_release("ovr");

      // ack on the same edge as a new capture
      do_press("coin first", 3'b001, 3'b001);
      btn_raw = 3'b011;
      exp_q.push_back(2'b01);
      k = 0;
      while (press_pulse == 3'b000 && k < 40) begin
         tick();
         k++;
      end
      chk("coin pulse edge", k, N + 2);
      chk("coin pulse bits", int'(press_pulse), 3'b010);
      ev_if.press_ack = 1'b1;
      tick();
      ev_if.press_ack = 1'b0;
      chk("coin valid stays", int'(ev_if.press_valid), 1);
      pop_chk("coin");
      ack_release("coin");

      // reset while button 1 is held in PRESSED
      do_press("rst pre", 3'b010, 3'b010);
      ev_if.press_ack = 1'b1;
      tick();
      ev_if.press_ack = 1'b0;
      chk("rst held fsm", int'(ev_if.dbg_state[3:2]), int'(ST_PRESSED));
      #2;
      reset = 1'b0;
      #1;
      chk("midrst level", int'(btn_level), 0);
      chk("midrst pulse", int'(press_pulse), 0);
      chk("midrst valid", int'(ev_if.press_valid), 0);
      chk("midrst code", int'(ev_if.press_code), 0);
      chk("midrst overrun", int'(ev_if.overrun), 0);
      tick();
      tick();
      reset = 1'b1;
      exp_q.push_back(2'b01);
      k = 0;
      while (press_pulse == 3'b000 && k < 40) begin
         tick();
         k++;
      end
      chk("postrst pulse edge", k, N + 2);
      chk("postrst pulse bits", int'(press_pulse), 3'b010);
      tick();
      chk("postrst valid", int'(ev_if.press_valid), 1);
      pop_chk("postrst");
      ack_release("postrst");

      chk("scoreboard drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
